uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmit engine with an internal byte FIFO: next-generation TX path for the UART interface top, replacing the fixed 8N1 single-character transmitter. Host logic (button/switch handlers, message generators) pushes characters without waiting on the line. The engine serialises them back-to-back onto `terminal_tx` with configurable data width, parity and stop bits.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer truncation, must be ≥ 2)
- `DATA_BITS`, 8, character width, legal 5–8
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, legal 1 or 2
- `FIFO_DEPTH`, 16, entries, power of two, ≥ 2

- `clk_100mhz` in 1: system clock, all logic on the rising edge
- `sys_rst_i` in 1: synchronous reset, active-high
- `wr_data_i` in DATA_BITS: character to enqueue
- `wr_en_i` in 1: enqueue request, one character per asserted cycle
- `clr_ovf_i` in 1: clears `overflow_o`
- `terminal_tx` out 1: serial line, idle high
- `full_o` out 1: FIFO holds FIFO_DEPTH entries
- `empty_o` out 1: FIFO holds 0 entries
- `level_o` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy
- `busy_o` out 1: FSM not in IDLE
- `overflow_o` out 1: sticky, a write was dropped

## Operation
- All outputs are registered. Reset values: `terminal_tx`=1, `busy_o`=0, `full_o`=0, `empty_o`=1, `level_o`=0, `overflow_o`=0. Reset also clears the FIFO pointers and the baud counter.
- FIFO: write accepted iff `wr_en_i` && !`full_o`. Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. `level_o` increments on accepted write, decrements on pop, and is unchanged when both happen in the same cycle.
- Write while `full_o`=1: data is dropped and `overflow_o` is set. This holds even if a pop occurs in the same cycle. If `clr_ovf_i` and a dropped write coincide, the set wins.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `terminal_tx`=1. When the FIFO is non-empty, pop the head into the shift register and enter START.
  - START: line 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
  - PARITY (only if PARITY≠0): even parity is the XOR of the data bits; odd parity is its inverse.
  - STOP: line 1 for STOP_BITS×CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts at every state or bit change. It does not free-run in IDLE.
- `sys_rst_i` mid-frame: frame aborted, `terminal_tx`=1 the cycle after the reset edge, FIFO contents discarded.

## Timing
- Write at rising edge k into an empty FIFO with the FSM in IDLE:
  - `empty_o`=0 and `level_o`=1 after edge k.
  - Pop at edge k+1, so `level_o` returns to 0 after edge k+1.
  - `terminal_tx` falls and `busy_o` rises after edge k+1.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back characters: the next start bit begins on the cycle immediately after the last stop cycle.
- `busy_o` falls on the same edge `terminal_tx` enters IDLE after the final stop bit.

## Test plan
- Config CLKS_PER_BIT=10 (BAUD=10_000_000), 8 data bits, even parity, 1 stop. Write 0x55 → line reads 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 10 cycles. Total 110 cycles, then `busy_o`=0.
- Same config with PARITY=1. Write 0xA5 (LSB-first data 1,0,1,0,0,1,0,1) → parity bit 1. Then set DATA_BITS=7, STOP_BITS=2, write 0x7F → 7 data ones, parity 0, and 20 cycles high before IDLE.
- Burst-write 0x41, 0x42, 0x43 on consecutive cycles → `level_o` peaks at 2. Three frames with no idle gap between them; `empty_o`=1 after the third pop.
- FIFO_DEPTH=4: write 6 characters in consecutive cycles while the first frame is in progress → exactly 5 transmitted (1 popped + 4 stored). `full_o`=1, `overflow_o`=1 sticky until a `clr_ovf_i` pulse clears it.
- Simultaneous pop and write at `level_o`=2 → `level_o` stays 2 and the data order is preserved.
- Assert `sys_rst_i` for 1 cycle during the DATA state of a frame with 3 characters queued → `terminal_tx`=1, `level_o`=0, `busy_o`=0 the next cycle, and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal character FIFO. Frames are sent back-to-back
// with configurable data width, parity (none/odd/even) and one or two stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_100mhz,
  input  logic                          sys_rst_i,
  input  logic [DATA_BITS-1:0]          wr_data_i,
  input  logic                          wr_en_i,
  input  logic                          clr_ovf_i,
  output logic                          terminal_tx,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          overflow_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  push, drop, pop, load, bit_end;
  logic [DATA_BITS-1:0]  head;
  logic [DATA_BITS-1:0]  fifo_mem [FIFO_DEPTH];

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  assign head    = fifo_mem[rd_ptr_q];
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    push     = wr_en_i && !full_q;
    drop     = wr_en_i && full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (!push && pop)
      level_d = level_q - LW'(1);
    full_d  = (level_d == LW'(FIFO_DEPTH));
    empty_d = (level_d == '0);
    // A dropped write takes priority over a clear in the same cycle.
    ovf_d   = drop | (ovf_q & ~clr_ovf_i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        load   = !empty_q;
      end
      S_START: if (bit_end) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_DATA;
        tx_d    = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        cnt_d = '0;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          bit_d = '0;
          if (PARITY != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      S_PARITY: if (bit_end) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
      S_STOP: if (bit_end) begin
        cnt_d = '0;
        if (bit_q == BW'(STOP_BITS - 1)) begin
          bit_d = '0;
          if (!empty_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loading the next character starts its start bit on the following cycle.
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = parity_bit(head);
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push)
      fifo_mem[wr_ptr_q] <= wr_data_i;
  end

  assign terminal_tx = tx_q;
  assign busy_o      = busy_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three configurations share one clock; a serial
// receiver decodes the line and compares each character against a scoreboard queue.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] wdata;
  logic [2:0] wen;
  logic [2:0] tx, busy, full, empty, ovf;
  logic [2:0] lvl [3];
  logic [7:0] sb [$];
  int         n_run = 0;
  int         n_fail = 0;
  int         gap;

  always #5 clk = ~clk;

  // 0: 8 data, even parity, 1 stop; 1: 8 data, odd, 1 stop; 2: 7 data, odd, 2 stop.
  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk_100mhz(clk), .sys_rst_i(rst), .wr_data_i(wdata), .wr_en_i(wen[0]),
    .clr_ovf_i(clr), .terminal_tx(tx[0]), .full_o(full[0]), .empty_o(empty[0]),
    .level_o(lvl[0]), .busy_o(busy[0]), .overflow_o(ovf[0]));

  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk_100mhz(clk), .sys_rst_i(rst), .wr_data_i(wdata), .wr_en_i(wen[1]),
    .clr_ovf_i(clr), .terminal_tx(tx[1]), .full_o(full[1]), .empty_o(empty[1]),
    .level_o(lvl[1]), .busy_o(busy[1]), .overflow_o(ovf[1]));

  uart_tx_fifo #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk_100mhz(clk), .sys_rst_i(rst), .wr_data_i(wdata[6:0]), .wr_en_i(wen[2]),
    .clr_ovf_i(clr), .terminal_tx(tx[2]), .full_o(full[2]), .empty_o(empty[2]),
    .level_o(lvl[2]), .busy_o(busy[2]), .overflow_o(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the next rising edge.
  task automatic push(input int s, input logic [7:0] d, input bit accepted);
    wdata  = d;
    wen[s] = 1'b1;
    if (accepted) sb.push_back((s == 2) ? (d & 8'h7F) : d);
    @(negedge clk);
    wen[s] = 1'b0;
  endtask

  // Waits for a start bit, samples each bit mid-period and returns at the middle of the last stop bit.
  task automatic rx(input int s, input int nb, input int par, input int ns, output int g);
    logic [7:0] d, e;
    logic       p;
    g = 0;
    while (tx[s] === 1'b1 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("start_edge", tx[s], 0);
    repeat (5) @(negedge clk);
    chk("start_mid", tx[s], 0);
    d = '0;
    for (int i = 0; i < nb; i++) begin
      repeat (10) @(negedge clk);
      d[i] = tx[s];
    end
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = 8'h00;
    chk("rx_data", d, e);
    if (par != 0) begin
      repeat (10) @(negedge clk);
      p = ^e;
      if (par == 1) p = ~p;
      chk("parity", tx[s], p);
    end
    for (int i = 0; i < ns; i++) begin
      repeat (10) @(negedge clk);
      chk("stop", tx[s], 1);
    end
  endtask

  // From the middle of the final stop bit: busy must drop exactly at frame cycle 110.
  task automatic done_chk(input int s);
    repeat (4) @(negedge clk);
    chk("busy_last_cycle", busy[s], 1);
    @(negedge clk);
    chk("busy_fall", busy[s], 0);
    chk("idle_line", tx[s], 1);
  endtask

  task automatic quiet(input int s, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx[s] !== 1'b1) lows++;
    end
    chk("line_quiet", lows, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wen = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", tx[s], 1);
      chk("rst_busy", busy[s], 0);
      chk("rst_full", full[s], 0);
      chk("rst_empty", empty[s], 1);
      chk("rst_level", lvl[s], 0);
      chk("rst_ovf", ovf[s], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single character, even parity, with cycle-exact latency checks.
    push(0, 8'h55, 1);
    chk("t1_empty", empty[0], 0);
    chk("t1_level1", lvl[0], 1);
    chk("t1_tx_idle", tx[0], 1);
    chk("t1_busy0", busy[0], 0);
    @(negedge clk);
    chk("t1_level0", lvl[0], 0);
    chk("t1_empty1", empty[0], 1);
    chk("t1_tx_start", tx[0], 0);
    chk("t1_busy1", busy[0], 1);
    rx(0, 8, 2, 1, gap);
    done_chk(0);

    // Odd parity, then 7 data bits with two stop bits.
    push(1, 8'hA5, 1);
    rx(1, 8, 1, 1, gap);
    done_chk(1);
    push(2, 8'h7F, 1);
    rx(2, 7, 1, 2, gap);
    done_chk(2);

    // Burst of three; the bench is one cycle into frame 0 when decoding begins.
    push(0, 8'h41, 1);
    chk("t3_lvl_a", lvl[0], 1);
    push(0, 8'h42, 1);
    chk("t3_lvl_b", lvl[0], 1);
    push(0, 8'h43, 1);
    chk("t3_lvl_peak", lvl[0], 2);
    rx(0, 8, 2, 1, gap);
    rx(0, 8, 2, 1, gap);
    chk("t3_gap1", gap, 4);
    rx(0, 8, 2, 1, gap);
    chk("t3_gap2", gap, 5);
    chk("t3_empty", empty[0], 1);
    chk("t3_level", lvl[0], 0);
    done_chk(0);

    // Overflow with a depth-4 FIFO: six writes, five transmitted.
    push(0, 8'h61, 1);
    push(0, 8'h62, 1);
    push(0, 8'h63, 1);
    push(0, 8'h64, 1);
    push(0, 8'h65, 1);
    push(0, 8'h66, 0);
    chk("t4_full", full[0], 1);
    chk("t4_ovf", ovf[0], 1);
    chk("t4_level", lvl[0], 4);
    rx(0, 8, 2, 1, gap);
    rx(0, 8, 2, 1, gap);
    chk("t4_gap1", gap, 1);
    chk("t4_level3", lvl[0], 3);
    chk("t4_not_full", full[0], 0);
    chk("t4_ovf_sticky", ovf[0], 1);
    for (int i = 0; i < 3; i++) begin
      rx(0, 8, 2, 1, gap);
      chk("t4_gap", gap, 5);
    end
    done_chk(0);
    quiet(0, 150);
    chk("t4_ovf_still", ovf[0], 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_ovf_cleared", ovf[0], 0);

    // Write lands on the same edge as a pop with two entries queued.
    push(0, 8'h10, 1);
    push(0, 8'h20, 1);
    push(0, 8'h30, 1);
    rx(0, 8, 2, 1, gap);
    repeat (3) @(negedge clk);
    chk("t5_lvl_before", lvl[0], 2);
    push(0, 8'h40, 1);
    chk("t5_lvl_same", lvl[0], 2);
    chk("t5_next_start", tx[0], 0);
    rx(0, 8, 2, 1, gap);
    chk("t5_gap0", gap, 0);
    rx(0, 8, 2, 1, gap);
    chk("t5_gap1", gap, 5);
    rx(0, 8, 2, 1, gap);
    chk("t5_gap2", gap, 5);
    done_chk(0);

    // Reset in the middle of the data bits with three characters queued.
    push(0, 8'h71, 1);
    push(0, 8'h72, 1);
    push(0, 8'h73, 1);
    push(0, 8'h74, 1);
    repeat (30) @(negedge clk);
    chk("t6_busy_pre", busy[0], 1);
    chk("t6_level_pre", lvl[0], 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("t6_tx", tx[0], 1);
    chk("t6_level", lvl[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_empty", empty[0], 1);
    quiet(0, 400);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
